flat_priority_scheduler: RTL and testbench

FLAT_PRIORITY_SCHEDULER -- requirements
Module: flat_priority_scheduler

---
 rtl/flat_priority_scheduler_if.sv | 24 ++
 rtl/flat_priority_scheduler.sv | 123 ++++++++++++
 tb/tb_flat_priority_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/flat_priority_scheduler_if.sv
// Request/grant bundle between the per-port cell queues and the flat priority scheduler.
// i_req is a level-sensitive "queue non-empty" flag vector, i_ready is a per-cycle accept; a read is issued only when both are seen in IDLE, o_rd is a one-cycle strobe, and o_valid follows it one cycle later.
interface flat_priority_scheduler_if #(
    parameter int PORT     = 8,
    parameter int PRIORITY = 4
);
    logic [PORT*PRIORITY-1:0] i_req;
    logic                     i_ready;
    logic                     o_rd;
    logic [PORT-1:0]          o_rd_port;
    logic [PRIORITY-1:0]      o_rd_priority;
    logic                     o_valid;
    logic                     o_busy;

    modport master (
        output i_req, i_ready,
        input  o_rd, o_rd_port, o_rd_priority, o_valid, o_busy
    );

    modport slave (
        input  i_req, i_ready,
        output o_rd, o_rd_port, o_rd_priority, o_valid, o_busy
    );
endinterface

// File: rtl/flat_priority_scheduler.sv
// Strict-priority level select with a round-robin port pointer per level.
// One read every three cycles: IDLE decides, ISSUE strobes o_rd, SETTLE strobes o_valid.
module flat_priority_scheduler #(
    parameter int PORT     = 8,
    parameter int PRIORITY = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    flat_priority_scheduler_if.slave bus,
    output logic [1:0]               o_dbg_state
);
    localparam int PW = (PORT > 1) ? $clog2(PORT) : 1;
    localparam int LW = (PRIORITY > 1) ? $clog2(PRIORITY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    state_e              state_q;
    logic [PW-1:0]       ptr_q [PRIORITY];
    logic [PW-1:0]       gnt_port_q;
    logic [LW-1:0]       gnt_lvl_q;
    logic                rd_q;
    logic                valid_q;
    logic [PORT-1:0]     rd_port_q;
    logic [PRIORITY-1:0] rd_pri_q;

    logic                sel_found;
    logic [LW-1:0]       sel_lvl_d;
    logic [PW-1:0]       sel_port_d;
    logic [PORT-1:0]     lvl_bits;
    logic [PW-1:0]       ptr_sel;
    logic                port_found;

    always_comb begin : select
        int cand;
        sel_found  = 1'b0;
        sel_lvl_d  = '0;
        sel_port_d = '0;
        lvl_bits   = '0;
        ptr_sel    = '0;
        port_found = 1'b0;
        cand       = 0;
        for (int l = 0; l < PRIORITY; l++) begin
            if (!sel_found && (|bus.i_req[l*PORT +: PORT])) begin
                sel_found = 1'b1;
                sel_lvl_d = LW'(l);
                lvl_bits  = bus.i_req[l*PORT +: PORT];
                ptr_sel   = ptr_q[l];
            end
        end
        // Search starts at the level's pointer and wraps past the top port.
        for (int k = 0; k < PORT; k++) begin
            cand = (int'(ptr_sel) + k) % PORT;
            if (!port_found && lvl_bits[PW'(cand)]) begin
                port_found = 1'b1;
                sel_port_d = PW'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_port_q <= '0;
            gnt_lvl_q  <= '0;
            rd_q       <= 1'b0;
            valid_q    <= 1'b0;
            rd_port_q  <= '0;
            rd_pri_q   <= '0;
            for (int l = 0; l < PRIORITY; l++) begin
                ptr_q[l] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.i_ready && sel_found) begin
                        state_q    <= ISSUE;
                        gnt_port_q <= sel_port_d;
                        gnt_lvl_q  <= sel_lvl_d;
                        rd_q       <= 1'b1;
                        rd_port_q  <= PORT'(1) << sel_port_d;
                        rd_pri_q   <= PRIORITY'(1) << sel_lvl_d;
                    end
                end
                ISSUE: begin
                    state_q   <= SETTLE;
                    rd_q      <= 1'b0;
                    rd_port_q <= '0;
                    rd_pri_q  <= '0;
                    valid_q   <= 1'b1;
                    // Pointer moves only once the read has actually been issued.
                    for (int l = 0; l < PRIORITY; l++) begin
                        if (gnt_lvl_q == LW'(l)) begin
                            ptr_q[l] <= (gnt_port_q == PW'(PORT - 1)) ? '0 : gnt_port_q + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    rd_q      <= 1'b0;
                    valid_q   <= 1'b0;
                    rd_port_q <= '0;
                    rd_pri_q  <= '0;
                end
            endcase
        end
    end

    assign bus.o_rd          = rd_q;
    assign bus.o_rd_port     = rd_port_q;
    assign bus.o_rd_priority = rd_pri_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_busy        = (state_q != IDLE);
    assign o_dbg_state       = state_q;
endmodule

// File: tb/tb_flat_priority_scheduler.sv
// Directed bench for flat_priority_scheduler: expected grants are queued by hand and popped per read.
module tb_flat_priority_scheduler;
    localparam int PORT     = 8;
    localparam int PRIORITY = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    logic [11:0] exp_q[$];
    int          n_checks;
    int          n_errors;

    flat_priority_scheduler_if #(.PORT(PORT), .PRIORITY(PRIORITY)) bus ();

    flat_priority_scheduler #(.PORT(PORT), .PRIORITY(PRIORITY)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input logic [3:0] pri, input logic [7:0] port);
        exp_q.push_back({pri, port});
    endtask

    task automatic drive(input logic [31:0] req, input logic ready);
        bus.i_req   = req;
        bus.i_ready = ready;
    endtask

    // Called at a negedge with the DUT in IDLE and inputs already driven.
    task automatic grant_cycle(input string tag);
        logic [11:0] e;
        e = 12'h000;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
        end
        @(negedge clk);
        check({tag, "_rd"}, 32'(bus.o_rd), 32'd1);
        check({tag, "_pri"}, 32'(bus.o_rd_priority), 32'(e[11:8]));
        check({tag, "_port"}, 32'(bus.o_rd_port), 32'(e[7:0]));
        check({tag, "_busy_issue"}, 32'(bus.o_busy), 32'd1);
        @(negedge clk);
        check({tag, "_rd_settle"}, 32'(bus.o_rd), 32'd0);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
        check({tag, "_port_settle"}, 32'(bus.o_rd_port), 32'd0);
        @(negedge clk);
        check({tag, "_valid_idle"}, 32'(bus.o_valid), 32'd0);
        check({tag, "_busy_idle"}, 32'(bus.o_busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(32'h0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_rd", 32'(bus.o_rd), 32'd0);
        check("reset_port", 32'(bus.o_rd_port), 32'd0);
        check("reset_pri", 32'(bus.o_rd_priority), 32'd0);
        check("reset_valid", 32'(bus.o_valid), 32'd0);
        check("reset_busy", 32'(bus.o_busy), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        // single request, level 0 port 0; then ports 0,1 show the pointer moved to 1
        drive(32'h0000_0001, 1'b1);
        expect_grant(4'h1, 8'h01);
        grant_cycle("first");
        drive(32'h0000_0003, 1'b1);
        expect_grant(4'h1, 8'h02);
        grant_cycle("ptr_after_first");
        drive(32'h0, 1'b1);

        // full level 0 from a fresh pointer: 0..7 then wrap to 0
        do_reset();
        drive(32'h0000_00FF, 1'b1);
        for (int p = 0; p < 9; p++) begin
            expect_grant(4'h1, 8'(1 << (p % 8)));
        end
        for (int p = 0; p < 9; p++) begin
            grant_cycle($sformatf("rr%0d", p));
        end

        // ptr0=1: port 6 moves it to 7, then 0x81 wraps 7 -> 0, then 0x03 gives port 1
        drive(32'h0000_0040, 1'b1);
        expect_grant(4'h1, 8'h40);
        grant_cycle("to_ptr7");
        drive(32'h0000_0081, 1'b1);
        expect_grant(4'h1, 8'h80);
        expect_grant(4'h1, 8'h01);
        grant_cycle("wrap_p7");
        grant_cycle("wrap_p0");
        drive(32'h0000_0003, 1'b1);
        expect_grant(4'h1, 8'h02);
        grant_cycle("after_wrap");

        // level 1 port 6 beats level 2 port 3 until it clears
        drive((32'h1 << 19) | (32'h1 << 14), 1'b1);
        expect_grant(4'h2, 8'h40);
        expect_grant(4'h2, 8'h40);
        grant_cycle("strict_a");
        grant_cycle("strict_b");
        drive(32'h1 << 19, 1'b1);
        expect_grant(4'h4, 8'h08);
        grant_cycle("strict_low");

        // ready low holds off; level 1 ptr is 7 so ports 0..3 wrap to port 0
        drive(32'h0000_0F00, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("noready_rd%0d", c), 32'(bus.o_rd), 32'd0);
            check($sformatf("noready_busy%0d", c), 32'(bus.o_busy), 32'd0);
        end
        drive(32'h0000_0F00, 1'b1);
        expect_grant(4'h2, 8'h01);
        grant_cycle("ready_rise");

        // request dropped right after issue: read still completes
        drive(32'h1 << 29, 1'b1);
        @(negedge clk);
        check("drop_rd", 32'(bus.o_rd), 32'd1);
        check("drop_pri", 32'(bus.o_rd_priority), 32'h8);
        check("drop_port", 32'(bus.o_rd_port), 32'h20);
        drive(32'h0, 1'b0);
        @(negedge clk);
        check("drop_valid", 32'(bus.o_valid), 32'd1);
        @(negedge clk);
        check("drop_idle", 32'(bus.o_busy), 32'd0);

        // async reset during ISSUE; level 0 ptr is 2 before the abort
        drive(32'h0000_0001, 1'b1);
        @(negedge clk);
        check("abort_rd_before", 32'(bus.o_rd), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rd", 32'(bus.o_rd), 32'd0);
        check("abort_valid", 32'(bus.o_valid), 32'd0);
        check("abort_port", 32'(bus.o_rd_port), 32'd0);
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        drive(32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post_abort_valid%0d", c), 32'(bus.o_valid), 32'd0);
            check($sformatf("post_abort_rd%0d", c), 32'(bus.o_rd), 32'd0);
        end
        drive(32'h0000_0006, 1'b1);
        expect_grant(4'h1, 8'h02);
        grant_cycle("ptr_cleared");
        drive(32'h0, 1'b0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
